// File: rtl/key_debounce_if.sv
// Key conditioning bus: the raw pins in, and clean levels and event pulses out.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;
  logic              key_any;

  // The debouncer side takes the pins and produces the conditioned events.
  modport master (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_long,
    output key_repeat,
    output key_any
  );

  // The consumer side drives the pins and reads the conditioned events.
  modport slave (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_repeat,
    input  key_any
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: per key a two-flop synchronizer, a debounce FSM and
// a long-press / auto-repeat generator. Internally 1 always means pressed.
module key_debounce #(
  parameter int              N_KEYS       = 4,
  parameter bit              ACTIVE_LOW   = 1'b1,
  parameter int              CNT_W        = 24,
  parameter logic [CNT_W-1:0] DB_TICKS     = 24'd1000000,
  parameter logic [CNT_W-1:0] LONG_TICKS   = 24'd8000000,
  parameter logic [CNT_W-1:0] REPEAT_TICKS = 24'd2000000
) (
  input  logic           CLK_i,
  input  logic           reset,
  key_debounce_if.master bus
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LAST     = DB_TICKS - CNT_ONE;
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TICKS - CNT_ONE;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_TICKS - CNT_ONE;

  // Value the synchronizer holds when no key is pressed.
  localparam logic [N_KEYS-1:0] RELEASED = {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] pressed_s;

  logic [1:0]       state_r    [N_KEYS];
  logic [1:0]       state_s    [N_KEYS];
  logic [CNT_W-1:0] db_cnt_r   [N_KEYS];
  logic [CNT_W-1:0] db_cnt_s   [N_KEYS];
  logic [CNT_W-1:0] hold_cnt_r [N_KEYS];
  logic [CNT_W-1:0] hold_cnt_s [N_KEYS];

  logic [N_KEYS-1:0] long_done_r, long_done_s;
  logic [N_KEYS-1:0] level_r, level_s;
  logic [N_KEYS-1:0] press_r, press_s;
  logic [N_KEYS-1:0] release_r, release_s;
  logic [N_KEYS-1:0] long_r, long_s;
  logic [N_KEYS-1:0] repeat_r, repeat_s;
  logic              any_r;

  // Two-flop synchronizer bringing the asynchronous pins into CLK_i.
  always_ff @(posedge CLK_i) begin
    if (!reset) begin
      sync1_r <= RELEASED;
      sync2_r <= RELEASED;
    end else begin
      sync1_r <= bus.key_raw;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = sync2_r ^ RELEASED;

  // Next-state and pulse decode for every key's debounce / hold FSM.
  always_comb begin
    long_done_s = long_done_r;
    level_s     = level_r;
    press_s     = {N_KEYS{1'b0}};
    release_s   = {N_KEYS{1'b0}};
    long_s      = {N_KEYS{1'b0}};
    repeat_s    = {N_KEYS{1'b0}};
    for (int k = 0; k < N_KEYS; k++) begin
      state_s[k]    = state_r[k];
      db_cnt_s[k]   = db_cnt_r[k];
      hold_cnt_s[k] = hold_cnt_r[k];
      case (state_r[k])
        ST_IDLE: begin
          if (pressed_s[k]) begin
            state_s[k]  = ST_PRESS_DB;
            db_cnt_s[k] = CNT_ZERO;
          end else begin
            state_s[k] = ST_IDLE;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed_s[k]) begin
            state_s[k]  = ST_IDLE;
            db_cnt_s[k] = CNT_ZERO;
          end else if (db_cnt_r[k] == DB_LAST) begin
            state_s[k]     = ST_PRESSED;
            level_s[k]     = 1'b1;
            press_s[k]     = 1'b1;
            hold_cnt_s[k]  = CNT_ZERO;
            long_done_s[k] = 1'b0;
          end else begin
            db_cnt_s[k] = db_cnt_r[k] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!pressed_s[k]) begin
            state_s[k]  = ST_RELEASE_DB;
            db_cnt_s[k] = CNT_ZERO;
          end else if (!long_done_r[k] && (hold_cnt_r[k] == LONG_LAST)) begin
            long_s[k]      = 1'b1;
            long_done_s[k] = 1'b1;
            hold_cnt_s[k]  = CNT_ZERO;
          end else if (long_done_r[k] && (hold_cnt_r[k] == REPEAT_LAST)) begin
            repeat_s[k]   = 1'b1;
            hold_cnt_s[k] = CNT_ZERO;
          end else begin
            hold_cnt_s[k] = hold_cnt_r[k] + CNT_ONE;
          end
        end
        ST_RELEASE_DB: begin
          // The hold counter is frozen here so a release glitch only delays
          // the long/repeat schedule instead of restarting it.
          if (pressed_s[k]) begin
            state_s[k]  = ST_PRESSED;
            db_cnt_s[k] = CNT_ZERO;
          end else if (db_cnt_r[k] == DB_LAST) begin
            state_s[k]   = ST_IDLE;
            db_cnt_s[k]  = CNT_ZERO;
            level_s[k]   = 1'b0;
            release_s[k] = 1'b1;
          end else begin
            db_cnt_s[k] = db_cnt_r[k] + CNT_ONE;
          end
        end
        default: begin
          state_s[k]     = ST_IDLE;
          db_cnt_s[k]    = CNT_ZERO;
          hold_cnt_s[k]  = CNT_ZERO;
          long_done_s[k] = 1'b0;
          level_s[k]     = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK_i) begin
    if (!reset) begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_r[k]    <= ST_IDLE;
        db_cnt_r[k]   <= CNT_ZERO;
        hold_cnt_r[k] <= CNT_ZERO;
      end
      long_done_r <= {N_KEYS{1'b0}};
      level_r     <= {N_KEYS{1'b0}};
      press_r     <= {N_KEYS{1'b0}};
      release_r   <= {N_KEYS{1'b0}};
      long_r      <= {N_KEYS{1'b0}};
      repeat_r    <= {N_KEYS{1'b0}};
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_r[k]    <= state_s[k];
        db_cnt_r[k]   <= db_cnt_s[k];
        hold_cnt_r[k] <= hold_cnt_s[k];
      end
      long_done_r <= long_done_s;
      level_r     <= level_s;
      press_r     <= press_s;
      release_r   <= release_s;
      long_r      <= long_s;
      repeat_r    <= repeat_s;
    end
  end

  // Any-key summary, registered so it trails key_level by one cycle.
  always_ff @(posedge CLK_i) begin
    if (!reset) begin
      any_r <= 1'b0;
    end else begin
      any_r <= |level_r;
    end
  end

  assign bus.key_level   = level_r;
  assign bus.key_press   = press_r;
  assign bus.key_release = release_r;
  assign bus.key_long    = long_r;
  assign bus.key_repeat  = repeat_r;
  assign bus.key_any     = any_r;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high build are driven
// with the same logical key pattern and both are checked against a run-length
// reference model of the debounce / long-press / repeat rules.
module tb_key_debounce;

  localparam int DB     = 4;
  localparam int LONG   = 20;
  localparam int REPEAT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_debounce_if #(.N_KEYS(4)) ifa ();
  key_debounce_if #(.N_KEYS(4)) ifb ();

  key_debounce #(
    .N_KEYS(4), .ACTIVE_LOW(1'b1), .CNT_W(24),
    .DB_TICKS(24'd4), .LONG_TICKS(24'd20), .REPEAT_TICKS(24'd8)
  ) dut_a (.CLK_i(clk), .reset(reset), .bus(ifa));

  key_debounce #(
    .N_KEYS(4), .ACTIVE_LOW(1'b0), .CNT_W(24),
    .DB_TICKS(24'd4), .LONG_TICKS(24'd20), .REPEAT_TICKS(24'd8)
  ) dut_b (.CLK_i(clk), .reset(reset), .bus(ifb));

  int n_vec = 0;
  int n_err = 0;

  // reference model state (1 = pressed everywhere)
  logic [3:0] m_s1, m_s2, m_lvl, m_prev;
  int         m_run   [4];
  int         m_ticks [4];
  logic [3:0] e_level, e_press, e_release, e_long, e_repeat;
  logic       e_any;

  // pulse tallies taken from the active-low build for directed checks
  int obs_press [4];
  int obs_rel   [4];
  int obs_long  [4];
  int obs_rep   [4];

  task automatic model_step(input logic rst_v, input logic [3:0] p);
    logic s;
    e_press = 4'd0; e_release = 4'd0; e_long = 4'd0; e_repeat = 4'd0;
    if (!rst_v) begin
      m_s1 = 4'd0; m_s2 = 4'd0; m_lvl = 4'd0; m_prev = 4'd0; e_any = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_run[k] = 0; m_ticks[k] = 0;
      end
    end else begin
      e_any = |m_lvl;
      for (int k = 0; k < 4; k++) begin
        s = m_s2[k];
        if (s != m_lvl[k]) begin
          // a new level is accepted after DB+1 consecutive samples of it
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DB + 1) begin
            m_run[k] = 0;
            if (s) begin
              m_lvl[k] = 1'b1; e_press[k] = 1'b1; m_ticks[k] = 0;
            end else begin
              m_lvl[k] = 1'b0; e_release[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
          // held time only advances on back-to-back pressed samples
          if (m_lvl[k] && m_prev[k]) begin
            m_ticks[k] = m_ticks[k] + 1;
            if (m_ticks[k] == LONG) e_long[k] = 1'b1;
            else if (m_ticks[k] > LONG && ((m_ticks[k] - LONG) % REPEAT) == 0)
              e_repeat[k] = 1'b1;
          end
        end
        m_prev[k] = s;
      end
      m_s2 = m_s1;
      m_s1 = p;
    end
    e_level = m_lvl;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] p, input logic rst_v);
    ifa.key_raw = ~p;
    ifb.key_raw = p;
    reset = rst_v;
    @(posedge clk);
    #1;
    model_step(rst_v, p);
    chk("a_level",   ifa.key_level,   e_level);
    chk("a_press",   ifa.key_press,   e_press);
    chk("a_release", ifa.key_release, e_release);
    chk("a_long",    ifa.key_long,    e_long);
    chk("a_repeat",  ifa.key_repeat,  e_repeat);
    chk("a_any",     {3'd0, ifa.key_any}, {3'd0, e_any});
    chk("b_level",   ifb.key_level,   e_level);
    chk("b_press",   ifb.key_press,   e_press);
    chk("b_release", ifb.key_release, e_release);
    chk("b_long",    ifb.key_long,    e_long);
    chk("b_repeat",  ifb.key_repeat,  e_repeat);
    chk("b_any",     {3'd0, ifb.key_any}, {3'd0, e_any});
    for (int k = 0; k < 4; k++) begin
      obs_press[k] += int'(ifa.key_press[k]);
      obs_rel[k]   += int'(ifa.key_release[k]);
      obs_long[k]  += int'(ifa.key_long[k]);
      obs_rep[k]   += int'(ifa.key_repeat[k]);
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) begin
      obs_press[k] = 0; obs_rel[k] = 0; obs_long[k] = 0; obs_rep[k] = 0;
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [3:0] pr;
  int         seg [4];

  initial begin
    pr = 4'd0;
    clear_obs();
    ifa.key_raw = 4'hF;
    ifb.key_raw = 4'h0;
    reset = 1'b0;

    // reset state
    repeat (3) cycle(4'd0, 1'b0);
    chk("reset_level", ifa.key_level, 4'd0);
    repeat (2) cycle(4'd0, 1'b1);

    // clean press on key 0: level and press on the 7th edge, any one later
    repeat (6) cycle(4'b0001, 1'b1);
    chk("s1_level_early", ifa.key_level, 4'd0);
    cycle(4'b0001, 1'b1);
    chk("s1_press_edge7", ifa.key_press, 4'b0001);
    chk("s1_any_lag", {3'd0, ifa.key_any}, 4'd0);
    cycle(4'b0001, 1'b1);
    chk("s1_press_width", ifa.key_press, 4'd0);
    chk("s1_any_rise", {3'd0, ifa.key_any}, 4'd1);
    repeat (10) cycle(4'd0, 1'b1);

    // bounce on key 1 never produces an event
    clear_obs();
    repeat (3) cycle(4'b0010, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (3) cycle(4'b0010, 1'b1);
    repeat (12) cycle(4'b0000, 1'b1);
    chk_int("s2_no_press", obs_press[1], 0);
    chk("s2_level", ifa.key_level, 4'd0);

    // key 2 long hold: one long, four repeats, then a single release
    clear_obs();
    repeat (7) cycle(4'b0100, 1'b1);
    chk("s3_press", ifa.key_press, 4'b0100);
    repeat (55) cycle(4'b0100, 1'b1);
    repeat (6) cycle(4'b0000, 1'b1);
    chk_int("s3_no_release_yet", obs_rel[2], 0);
    cycle(4'b0000, 1'b1);
    chk("s3_release_edge7", ifa.key_release, 4'b0100);
    repeat (20) cycle(4'b0000, 1'b1);
    chk_int("s3_long_count", obs_long[2], 1);
    chk_int("s3_repeat_count", obs_rep[2], 4);
    chk_int("s3_release_count", obs_rel[2], 1);

    // release glitch on key 3 while held: no release, long shifted later
    clear_obs();
    repeat (17) cycle(4'b1000, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (25) cycle(4'b1000, 1'b1);
    chk_int("s4_no_release", obs_rel[3], 0);
    chk_int("s4_long_once", obs_long[3], 1);
    chk("s4_level", ifa.key_level, 4'b1000);
    repeat (12) cycle(4'b0000, 1'b1);

    // simultaneous press on keys 0 and 3, then reset while held
    clear_obs();
    repeat (7) cycle(4'b1001, 1'b1);
    chk("s5_both_press", ifa.key_press, 4'b1001);
    repeat (3) cycle(4'b1001, 1'b1);
    cycle(4'b1001, 1'b0);
    chk("s5_reset_level", ifa.key_level, 4'd0);
    chk("s5_reset_release", ifa.key_release, 4'd0);
    repeat (6) cycle(4'b1001, 1'b1);
    chk("s5_no_early_press", ifa.key_press, 4'd0);
    cycle(4'b1001, 1'b1);
    chk("s5_repress_edge7", ifa.key_press, 4'b1001);
    chk_int("s5_no_release", obs_rel[0] + obs_rel[3], 0);
    repeat (12) cycle(4'd0, 1'b1);

    // randomized traffic: mixes short bounces with long holds, rare resets
    for (int k = 0; k < 4; k++) seg[k] = $urandom_range(1, 30);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (seg[k] == 0) begin
          pr[k] = ~pr[k];
          if ($urandom_range(0, 1) == 0) seg[k] = $urandom_range(1, 4);
          else seg[k] = $urandom_range(5, 70);
        end else begin
          seg[k] = seg[k] - 1;
        end
      end
      cycle(pr, ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
